// File: rtl/sdram_wr_pkg.sv
// Shared definitions for the SDRAM write burst feeder: FSM state encoding
// and the default widths used by the feeder's parameters.
package sdram_wr_pkg;

  // Burst FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_NEXT  = 2'd3;

  // Default widths (SDRAM Dq, row, column and bank address widths)
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ROW_W  = 12;
  localparam int DEFAULT_COL_W  = 9;
  localparam int DEFAULT_BA_W   = 2;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy output.
// The head word is read combinationally; it reads as zero while empty so the
// output is deterministic after reset without clearing the storage array.
module sdram_wr_fifo
  import sdram_wr_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  input  logic [DATA_W-1:0]          din,
  output logic                       din_ready,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              do_pop;

  assign din_ready = (level != FULL_LEVEL);
  assign push      = din_valid & din_ready;
  // Popping an empty FIFO is never requested by the feeder, but guard anyway
  assign do_pop    = pop & (level != '0);
  assign dout      = (level == '0) ? '0 : mem[rd_ptr];

  // Storage write; the array itself is not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sdram_wr_burst_feeder.sv
// Write-side feeder for the SDRAM main controller. Buffers a user word
// stream, requests a burst write once a full burst is buffered, streams the
// words out as the controller pulls them and advances the linear
// bank/row/column write address after every burst.
// Optional feature: define SDRAM_WR_OVF_CNT_EN to add the 16-bit saturating
// ovf_cnt output counting push attempts made while the FIFO is full.
module sdram_wr_burst_feeder
  import sdram_wr_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int ROW_W      = DEFAULT_ROW_W,
  parameter int COL_W      = DEFAULT_COL_W,
  parameter int BA_W       = DEFAULT_BA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  input  logic [DATA_W-1:0]            din,
  output logic                         din_ready,
  output logic                         wr_req,
  input  logic                         wr_ack,
  output logic [BA_W-1:0]              wr_bank,
  output logic [ROW_W-1:0]             wr_row,
  output logic [COL_W-1:0]             wr_col,
  input  logic                         wr_data_en,
  output logic [DATA_W-1:0]            wr_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy
`ifdef SDRAM_WR_OVF_CNT_EN
  ,
  output logic [15:0]                  ovf_cnt
`endif
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int ADDR_W = BA_W + ROW_W + COL_W;
  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              fifo_pop;

  // Words leave the FIFO only while a burst is being transferred
  assign fifo_pop = wr_data_en & (state_reg == ST_BURST);

  sdram_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .pop       (fifo_pop),
    .dout      (wr_data),
    .level     (fifo_level)
  );

  assign wr_req = (state_reg == ST_REQ);
  assign busy   = (state_reg != ST_IDLE);

  // The address is one linear counter; column overflow carries into the
  // row and row overflow into the bank, with the bank wrapping to zero.
  assign wr_col  = addr_reg[COL_W-1:0];
  assign wr_row  = addr_reg[COL_W +: ROW_W];
  assign wr_bank = addr_reg[COL_W+ROW_W +: BA_W];

  // Burst sequencing: wait for a full burst, handshake, count beats, advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= '0;
      addr_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fifo_level >= LVL_W'(BURST_LEN)) begin
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wr_ack) begin
            state_reg    <= ST_BURST;
            beat_cnt_reg <= '0;
          end
        end
        ST_BURST: begin
          if (wr_data_en) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            if (beat_cnt_reg == CNT_W'(BURST_LEN - 1)) begin
              state_reg <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          addr_reg  <= addr_reg + ADDR_W'(BURST_LEN);
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef SDRAM_WR_OVF_CNT_EN
  // Saturating count of push attempts rejected because the FIFO was full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (din_valid && !din_ready && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_wr_burst_feeder.sv
// Self-checking bench for sdram_wr_burst_feeder. A second instance with a
// tiny address space shares all inputs so row and bank wrap are reached in
// a few dozen bursts. The reference model is a word queue plus a burst count
// from which the expected addresses are derived arithmetically.
module tb_sdram_wr_burst_feeder;

  localparam int BL = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [15:0] din = '0;
  logic        wr_ack = 1'b0;
  logic        wr_data_en = 1'b0;

  logic        din_ready, wr_req, busy;
  logic [1:0]  wr_bank;
  logic [11:0] wr_row;
  logic [8:0]  wr_col;
  logic [15:0] wr_data;
  logic [4:0]  fifo_level;

  logic        din_ready2, wr_req2, busy2;
  logic [1:0]  wr_bank2;
  logic [1:0]  wr_row2;
  logic [2:0]  wr_col2;
  logic [15:0] wr_data2;
  logic [4:0]  fifo_level2;
`ifdef SDRAM_WR_OVF_CNT_EN
  logic [15:0] ovf_cnt, ovf_cnt2;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [15:0] q[$];
  int          n_bursts = 0;
  bit          in_burst = 0;
  int          pops_done = 0;
  int          ovf_model = 0;

  always #10 clk = ~clk;

  sdram_wr_burst_feeder dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_bank(wr_bank), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data_en(wr_data_en), .wr_data(wr_data),
    .fifo_level(fifo_level), .busy(busy)
`ifdef SDRAM_WR_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  sdram_wr_burst_feeder #(.ROW_W(2), .COL_W(3), .BA_W(2)) dut2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready2),
    .wr_req(wr_req2), .wr_ack(wr_ack), .wr_bank(wr_bank2), .wr_row(wr_row2),
    .wr_col(wr_col2), .wr_data_en(wr_data_en), .wr_data(wr_data2),
    .fifo_level(fifo_level2), .busy(busy2)
`ifdef SDRAM_WR_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt2)
`endif
  );

  // Expected {bank,row,col} after n bursts for a given geometry
  function automatic int exp_bank(int n, int col_w, int row_w, int ba_w);
    return ((n * BL) / ((1 << col_w) * (1 << row_w))) % (1 << ba_w);
  endfunction
  function automatic int exp_row(int n, int col_w, int row_w);
    return ((n * BL) / (1 << col_w)) % (1 << row_w);
  endfunction
  function automatic int exp_col(int n, int col_w);
    return (n * BL) % (1 << col_w);
  endfunction

  // One clock cycle of stimulus with the model updated on the same edge
  task automatic step(input logic v, input logic [15:0] d, input logic en, input logic ack);
    bit acc;
    din_valid = v; din = d; wr_data_en = en; wr_ack = ack;
    acc = v && (q.size() < DEPTH);
    if (v && !acc && ovf_model < 65535) ovf_model++;
    @(posedge clk);
    if (en && in_burst && q.size() > 0) begin
      void'(q.pop_front());
      pops_done++;
      if (pops_done == BL) in_burst = 0;
    end
    if (acc) q.push_back(d);
    #1;
  endtask

  task automatic check_addr(input string tag);
    int eb, er, ec;
    eb = exp_bank(n_bursts, 9, 12, 2); er = exp_row(n_bursts, 9, 12); ec = exp_col(n_bursts, 9);
    total++;
    if (wr_bank !== 2'(eb) || wr_row !== 12'(er) || wr_col !== 9'(ec)) begin
      bad++;
      $display("FAIL %s addr: got b%0d r%0d c%0d want b%0d r%0d c%0d", tag, wr_bank, wr_row, wr_col, eb, er, ec);
    end
    eb = exp_bank(n_bursts, 3, 2, 2); er = exp_row(n_bursts, 3, 2); ec = exp_col(n_bursts, 3);
    total++;
    if (wr_bank2 !== 2'(eb) || wr_row2 !== 2'(er) || wr_col2 !== 3'(ec)) begin
      bad++;
      $display("FAIL %s small addr: got b%0d r%0d c%0d want b%0d r%0d c%0d", tag, wr_bank2, wr_row2, wr_col2, eb, er, ec);
    end
  endtask

  // Complete one burst: top up, wait for request, ack, pull BL words, advance
  task automatic run_burst(input bit push_during);
    int guard;
    int dly;
    while (q.size() < BL) step(1, 16'($urandom), 0, 0);
    guard = 0;
    while (wr_req !== 1'b1 && guard < 8) begin step(0, '0, 0, 0); guard++; end
    total++;
    if (wr_req !== 1'b1) begin bad++; $display("FAIL req_timeout: got %b want 1", wr_req); end
    check_addr("req");
    dly = $urandom_range(0, 2);
    for (int i = 0; i < dly; i++) step(push_during, 16'($urandom), 0, 0);
    total++;
    if (wr_req !== 1'b1) begin bad++; $display("FAIL req_hold: got %b want 1", wr_req); end
    step(push_during, 16'($urandom), 0, 1);
    in_burst = 1; pops_done = 0;
    total++;
    if (wr_req !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL ack: got req=%b busy=%b want req=0 busy=1", wr_req, busy);
    end
    for (int p = 0; p < BL; p++) begin
      dly = $urandom_range(0, 2);
      for (int i = 0; i < dly; i++) step(push_during, 16'($urandom), 0, 0);
      total++;
      if (wr_data !== q[0]) begin bad++; $display("FAIL data beat%0d: got %h want %h", p, wr_data, q[0]); end
      step(push_during, 16'($urandom), 1, 0);
      total++;
      if (fifo_level !== 5'(q.size())) begin
        bad++; $display("FAIL level beat%0d: got %0d want %0d", p, fifo_level, q.size());
      end
    end
    // Address-advance cycle; a wr_data_en here must be ignored
    step(0, '0, 1, 0);
    n_bursts++;
    total++;
    if (busy !== 1'b0 || fifo_level !== 5'(q.size())) begin
      bad++; $display("FAIL after_burst: got busy=%b level=%0d want busy=0 level=%0d", busy, fifo_level, q.size());
    end
    check_addr("next");
  endtask

  task automatic test_reset;
    rst = 1'b1;
    din_valid = 0; wr_ack = 0; wr_data_en = 0;
    repeat (2) @(posedge clk);
    #5 rst = 1'b0;
    @(posedge clk); #1;
    q.delete(); n_bursts = 0; in_burst = 0; ovf_model = 0;
    total++;
    if (fifo_level !== 5'd0 || din_ready !== 1'b1 || wr_req !== 1'b0 || busy !== 1'b0 || wr_data !== 16'h0) begin
      bad++;
      $display("FAIL reset: got lvl=%0d rdy=%b req=%b busy=%b data=%h want 0 1 0 0 0", fifo_level, din_ready, wr_req, busy, wr_data);
    end
    check_addr("reset");
  endtask

  task automatic test_latency;
    step(1, 16'h1111, 0, 0);
    step(1, 16'h2222, 0, 0);
    step(1, 16'h3333, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    total++;
    if (wr_req !== 1'b0 || fifo_level !== 5'd3) begin
      bad++; $display("FAIL three_words: got req=%b lvl=%0d want req=0 lvl=3", wr_req, fifo_level);
    end
    step(1, 16'h4444, 0, 0);
    total++;
    if (wr_req !== 1'b0) begin bad++; $display("FAIL latency_t1: got %b want 0", wr_req); end
    step(0, '0, 0, 0);
    total++;
    if (wr_req !== 1'b1) begin bad++; $display("FAIL latency_t2: got %b want 1", wr_req); end
    check_addr("first_req");
  endtask

  task automatic test_burst_order;
    total++;
    if (q.size() != 4 || wr_data !== 16'h1111) begin
      bad++; $display("FAIL order_head: got %h want 1111", wr_data);
    end
    run_burst(0);
    total++;
    if (wr_col !== 9'd4) begin bad++; $display("FAIL col4: got %0d want 4", wr_col); end
  endtask

  task automatic test_addr_wrap;
    while (n_bursts < 127) run_burst(1'($urandom));
    total++;
    if (wr_col !== 9'd508 || wr_row !== 12'd0) begin
      bad++; $display("FAIL col508: got r%0d c%0d want r0 c508", wr_row, wr_col);
    end
    run_burst(0);
    total++;
    if (wr_col !== 9'd0 || wr_row !== 12'd1 || wr_bank !== 2'd0) begin
      bad++; $display("FAIL col_wrap: got b%0d r%0d c%0d want b0 r1 c0", wr_bank, wr_row, wr_col);
    end
  endtask

  task automatic test_full;
    while (q.size() < DEPTH) step(1, 16'($urandom), 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 16'($urandom), 0, 0);
      total++;
      if (din_ready !== 1'b0 || fifo_level !== 5'd16) begin
        bad++; $display("FAIL full%0d: got rdy=%b lvl=%0d want rdy=0 lvl=16", i, din_ready, fifo_level);
      end
    end
`ifdef SDRAM_WR_OVF_CNT_EN
    total++;
    if (ovf_cnt !== 16'(ovf_model)) begin
      bad++; $display("FAIL ovf_cnt: got %0d want %0d", ovf_cnt, ovf_model);
    end
`endif
    run_burst(1);
  endtask

  task automatic test_abort;
    int guard;
    while (q.size() < BL) step(1, 16'($urandom), 0, 0);
    guard = 0;
    while (wr_req !== 1'b1 && guard < 8) begin step(0, '0, 0, 0); guard++; end
    step(0, '0, 0, 1);
    in_burst = 1; pops_done = 0;
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    din_valid = 0; wr_data_en = 0; wr_ack = 0;
    #3 rst = 1'b1;
    #1;
    total++;
    if (wr_req !== 1'b0 || busy !== 1'b0 || fifo_level !== 5'd0 || wr_data !== 16'h0 ||
        wr_bank !== 2'd0 || wr_row !== 12'd0 || wr_col !== 9'd0) begin
      bad++;
      $display("FAIL async_abort: got req=%b busy=%b lvl=%0d data=%h b%0d r%0d c%0d want all 0",
               wr_req, busy, fifo_level, wr_data, wr_bank, wr_row, wr_col);
    end
    @(posedge clk);
    #5 rst = 1'b0;
    @(posedge clk); #1;
    q.delete(); n_bursts = 0; in_burst = 0; ovf_model = 0;
`ifdef SDRAM_WR_OVF_CNT_EN
    total++;
    if (ovf_cnt !== 16'd0) begin bad++; $display("FAIL ovf_reset: got %0d want 0", ovf_cnt); end
`endif
  endtask

  task automatic test_idle_ignore;
    step(1, 16'($urandom), 0, 0);
    step(1, 16'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 1);
    step(0, '0, 0, 0);
    total++;
    if (fifo_level !== 5'd2 || busy !== 1'b0 || wr_req !== 1'b0 || wr_data !== q[0]) begin
      bad++;
      $display("FAIL idle_ignore: got lvl=%0d busy=%b req=%b data=%h want 2 0 0 %h", fifo_level, busy, wr_req, wr_data, q[0]);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_burst_order;
    test_addr_wrap;
    test_full;
    test_abort;
    test_idle_ignore;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
